// File: rtl/alu_unit_if.sv
// Operand/result bundle for alu_unit: operands and select in, combinational
// result plus the registered result and status flags out.
interface alu_unit_if #(
  parameter int width_p = 8
);
  logic [1:0]         sel_i;
  logic [width_p-1:0] a_i;
  logic [width_p-1:0] b_i;
  logic               v_i;
  logic [width_p-1:0] res_o;
  logic [width_p-1:0] res_r_o;
  logic               v_r_o;
  logic               carry_r_o;
  logic               zero_r_o;
  logic               neg_r_o;
  logic               ovf_r_o;

  modport master (
    output sel_i, a_i, b_i, v_i,
    input  res_o, res_r_o, v_r_o, carry_r_o, zero_r_o, neg_r_o, ovf_r_o
  );

  modport slave (
    input  sel_i, a_i, b_i, v_i,
    output res_o, res_r_o, v_r_o, carry_r_o, zero_r_o, neg_r_o, ovf_r_o
  );
endinterface

// File: rtl/alu_unit.sv
// Two-operand ADD/SUB/AND/OR ALU: combinational result plus a one-cycle
// registered copy of the result with carry/zero/negative/overflow flags.
module alu_unit #(
  parameter int width_p = 8
) (
  input  logic     clk_i,
  input  logic     reset_i,
  alu_unit_if.slave bus
);
  localparam logic [1:0] sel_add = 2'b00;
  localparam logic [1:0] sel_sub = 2'b01;
  localparam logic [1:0] sel_and = 2'b10;
  localparam logic [1:0] sel_or  = 2'b11;

  logic [width_p:0]   sum;
  logic [width_p:0]   diff;
  logic [width_p-1:0] res;
  logic               carry;
  logic               ovf;
  logic               a_msb;
  logic               b_msb;
  logic               r_msb;

  // Extra top bit gives the ADD carry-out; for SUB it is the unsigned borrow.
  assign sum  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign diff = {1'b0, bus.a_i} - {1'b0, bus.b_i};

  assign a_msb = bus.a_i[width_p-1];
  assign b_msb = bus.b_i[width_p-1];
  assign r_msb = res[width_p-1];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (bus.sel_i)
      sel_add: begin
        res   = sum[width_p-1:0];
        carry = sum[width_p];
        ovf   = (a_msb == b_msb) && (r_msb != a_msb);
      end
      sel_sub: begin
        res   = diff[width_p-1:0];
        carry = diff[width_p];
        ovf   = (a_msb != b_msb) && (r_msb != a_msb);
      end
      sel_and: res = bus.a_i & bus.b_i;
      sel_or:  res = bus.a_i | bus.b_i;
      default: res = '0;
    endcase
  end

  assign bus.res_o = res;

  // v_i qualifies capture only: a 1 at an edge loads result and flags and
  // raises v_r_o; a 0 holds them and drops v_r_o. There is no backpressure.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus.res_r_o   <= '0;
      bus.v_r_o     <= 1'b0;
      bus.carry_r_o <= 1'b0;
      bus.zero_r_o  <= 1'b1;
      bus.neg_r_o   <= 1'b0;
      bus.ovf_r_o   <= 1'b0;
    end else begin
      bus.v_r_o <= bus.v_i;
      if (bus.v_i) begin
        bus.res_r_o   <= res;
        bus.carry_r_o <= carry;
        bus.zero_r_o  <= (res == '0);
        bus.neg_r_o   <= r_msb;
        bus.ovf_r_o   <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// Randomized and directed check of alu_unit at widths 8 and 16 against an
// integer-arithmetic reference model with an expected-state scoreboard.
module tb_alu_unit;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_unit_if #(.width_p(8))  if8  ();
  alu_unit_if #(.width_p(16)) if16 ();

  alu_unit #(.width_p(8))  dut8  (.clk_i(clk), .reset_i(reset), .bus(if8.slave));
  alu_unit #(.width_p(16)) dut16 (.clk_i(clk), .reset_i(reset), .bus(if16.slave));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected registered state: {v, ovf, neg, zero, carry, res[15:0]}
  logic [20:0] exp8_q[$];
  logic [20:0] exp16_q[$];
  logic [20:0] held8;
  logic [20:0] held16;
  localparam logic [20:0] reset_state = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};

  // Reference model: plain integer arithmetic on unsigned and signed views.
  // Returns {ovf, neg, zero, carry, res[15:0]}.
  function automatic logic [19:0] model(input int w, input logic [1:0] sel,
                                        input logic [15:0] a, input logic [15:0] b);
    longint m, half, ua, ub, sa, sb, full, sr, r;
    logic carry, ovf;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(a) % m;
    ub   = longint'(b) % m;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    carry = 1'b0;
    ovf   = 1'b0;
    full  = 0;
    case (sel)
      2'd0: begin
        full  = ua + ub;
        carry = (full >= m);
        sr    = sa + sb;
        ovf   = (sr >= half) || (sr < -half);
      end
      2'd1: begin
        full  = ua - ub;
        carry = (ua < ub);
        sr    = sa - sb;
        ovf   = (sr >= half) || (sr < -half);
      end
      2'd2: full = ua & ub;
      default: full = ua | ub;
    endcase
    r = ((full % m) + m) % m;
    return {ovf, (r >= half), (r == 0), carry, r[15:0]};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, got, exp);
    end
  endtask

  // driver: apply inputs, check combinational result, then account for the edge
  task automatic step(input logic rst, input logic v, input logic [1:0] sel,
                      input logic [15:0] a, input logic [15:0] b);
    logic [19:0] r8, r16;
    reset      = rst;
    if8.v_i    = v;   if16.v_i   = v;
    if8.sel_i  = sel; if16.sel_i = sel;
    if8.a_i    = a[7:0]; if16.a_i = a;
    if8.b_i    = b[7:0]; if16.b_i = b;
    r8  = model(8, sel, a, b);
    r16 = model(16, sel, a, b);
    #1;
    check("res_o_w8",  {13'h0, if8.res_o},  {5'h0, r8[15:0]});
    check("res_o_w16", {5'h0, if16.res_o},  {5'h0, r16[15:0]});
    @(posedge clk);
    if (rst) begin
      held8  = reset_state;
      held16 = reset_state;
    end else if (v) begin
      held8  = {1'b1, r8};
      held16 = {1'b1, r16};
    end else begin
      held8  = {1'b0, held8[19:0]};
      held16 = {1'b0, held16[19:0]};
    end
    exp8_q.push_back(held8);
    exp16_q.push_back(held16);
    #1;
  endtask

  // monitor / scoreboard: compare the registered stage every cycle it is expected
  always @(negedge clk) begin
    logic [20:0] e;
    if (exp8_q.size() > 0) begin
      e = exp8_q.pop_front();
      check("reg_w8", {if8.v_r_o, if8.ovf_r_o, if8.neg_r_o, if8.zero_r_o,
                       if8.carry_r_o, 8'h00, if8.res_r_o}, e);
    end
    if (exp16_q.size() > 0) begin
      e = exp16_q.pop_front();
      check("reg_w16", {if16.v_r_o, if16.ovf_r_o, if16.neg_r_o, if16.zero_r_o,
                        if16.carry_r_o, if16.res_r_o}, e);
    end
  end

  task automatic check_lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    check(name, {5'h0, got}, {5'h0, exp});
  endtask

  logic [15:0] edge_vals[6];

  initial begin
    held8  = reset_state;
    held16 = reset_state;
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF; edge_vals[2] = 16'h7FFF;
    edge_vals[3] = 16'h8000; edge_vals[4] = 16'h007F; edge_vals[5] = 16'h0080;

    step(1'b1, 1'b0, 2'd0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 2'd0, 16'h1, 16'h1);

    // Combinational ops with a=1, b=3, literal expectations
    for (int s = 0; s < 4; s++) begin
      reset = 1'b0;
      if8.v_i = 1'b0; if16.v_i = 1'b0;
      if8.sel_i = s[1:0]; if16.sel_i = s[1:0];
      if8.a_i = 8'h01; if16.a_i = 16'h0001;
      if8.b_i = 8'h03; if16.b_i = 16'h0003;
      #1;
      case (s)
        0: begin check_lit("add_w8", {8'h0, if8.res_o}, 16'h0004); check_lit("add_w16", if16.res_o, 16'h0004); end
        1: begin check_lit("sub_w8", {8'h0, if8.res_o}, 16'h00FE); check_lit("sub_w16", if16.res_o, 16'hFFFE); end
        2: begin check_lit("and_w8", {8'h0, if8.res_o}, 16'h0001); check_lit("and_w16", if16.res_o, 16'h0001); end
        default: begin check_lit("or_w8", {8'h0, if8.res_o}, 16'h0003); check_lit("or_w16", if16.res_o, 16'h0003); end
      endcase
    end

    // Directed registered scenarios
    step(1'b0, 1'b1, 2'd1, 16'h0001, 16'h0003);  // 1-3 borrow, negative
    step(1'b0, 1'b1, 2'd0, 16'h007F, 16'h0001);  // signed overflow at width 8
    step(1'b0, 1'b1, 2'd0, 16'h7FFF, 16'h0001);  // signed overflow at width 16
    step(1'b0, 1'b1, 2'd0, 16'hFFFF, 16'h0001);  // wrap to zero with carry
    step(1'b0, 1'b0, 2'd3, 16'h1234, 16'h4321);  // hold
    step(1'b0, 1'b0, 2'd2, 16'h5555, 16'hAAAA);  // hold again
    step(1'b0, 1'b1, 2'd1, 16'h8000, 16'h0001);  // capture before reset
    step(1'b1, 1'b1, 2'd0, 16'h0003, 16'h0004);  // reset overrides v_i
    step(1'b0, 1'b1, 2'd3, 16'h000F, 16'h00F0);  // first capture after reset
    step(1'b0, 1'b1, 2'd3, 16'h0F0F, 16'hF0F0);  // back-to-back

    // Randomized stream with edge-value bias
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 16'($urandom);
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), a, b);
    end

    @(posedge clk);
    @(posedge clk);
    check("drain_w8",  {16'h0, 5'(exp8_q.size())},  21'h0);
    check("drain_w16", {16'h0, 5'(exp16_q.size())}, 21'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
